// File: rtl/lsu.sv
// Load/store unit: sits between the core and a word-wide data memory.
// Byte/half stores use a read-modify-write; loads are lane-extracted and
// sign- or zero-extended before being returned.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a request
// LOAD    | memory read in flight, result captured on the edge
// RMW_RD  | read old word, merge the store lane on the edge
// WRITE   | single-cycle memory write of the merge register
// RESP    | completion pulse, no error
// ERR     | completion pulse with error, no memory access made
module lsu #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP, S_ERR
  } state_t;

  state_t        r_state;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic          r_mem_we;

  logic          w_misalign;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rdata;
  assign mem_we     = r_mem_we;
  assign mem_addr   = {r_addr[AW-1:2], 2'b00};
  assign mem_wd     = r_merge;

  // Alignment check on the incoming request (size 11 is always illegal)
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = (req_addr[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  // Load lane extraction and extension from the captured request
  always_comb begin
    w_byte = mem_rd[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rd[7:0];
      2'b01:   w_byte = mem_rd[15:8];
      2'b10:   w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rd;
    endcase
  end

  // Store lane merge: old word with the target lane replaced
  always_comb begin
    w_merge = mem_rd;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'b00:   w_merge[7:0]   = r_wdata[7:0];
        2'b01:   w_merge[15:8]  = r_wdata[7:0];
        2'b10:   w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else begin
      if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
      else           w_merge[15:0]  = r_wdata[15:0];
    end
  end

  // Sequencer with registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_merge      <= 32'h0;
      r_rdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_misalign) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!req_we) begin
              r_state <= S_LOAD;
            end else if (req_size == 2'b10) begin
              r_state  <= S_WRITE;
              r_merge  <= req_wdata;
              r_mem_we <= 1'b1;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          r_rdata      <= w_load;
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        S_RMW_RD: begin
          r_merge  <= w_merge;
          r_state  <= S_WRITE;
          r_mem_we <= 1'b1;
        end
        S_WRITE: begin
          r_rdata      <= 32'h0;
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small word memory model.
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:15];
  int          we_cnt;
  int          n_vec;
  int          n_err;

  lsu #(.AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr[5:2]] <= mem_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_garbage();
    req_we     = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b1;
    req_addr   = 32'h0000_003C;
    req_wdata  = 32'hBAD0_BAD0;
  endtask

  // One request from idle; watches every cycle until the response pulse.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd,
                      input int exp_cyc, input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_nwe, input logic [31:0] exp_wd);
    int          cyc;
    int          nwe;
    logic [31:0] seen_wd;
    logic        got;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    set_garbage();
    cyc = 0; nwe = 0; seen_wd = 32'h0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        nwe++;
        seen_wd = mem_wd;
      end
      if (resp_valid) got = 1'b1;
      if (cyc == 1) chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
    end
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_nwe"}, nwe, exp_nwe);
    if (exp_nwe > 0) chk({tag, "_wd"}, seen_wd, exp_wd);
  endtask

  logic        t_we  [0:4];
  logic [31:0] t_a   [0:4];
  logic [31:0] t_wd  [0:4];
  logic [31:0] t_rd  [0:4];
  int          t_gap [0:4];

  initial begin
    int w0;
    int n;
    logic seen;
    n_vec = 0; n_err = 0; we_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    mem[4] <= 32'h8899_AABB;
    mem[5] <= 32'h1122_3344;
    mem[6] <= 32'h0102_0304;
    reset = 1'b0;
    req_valid = 1'b0;
    set_garbage();
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rerr", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mwe", {31'b0, mem_we}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwd", mem_wd, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    xact("lw10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h8899_AABB, 0, 32'h0);
    xact("lb13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF88, 0, 32'h0);
    xact("lbu13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'h0000_0088, 0, 32'h0);
    xact("lh12",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_8899, 0, 32'h0);
    xact("lhu10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000_AABB, 0, 32'h0);
    xact("lbu11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'h0000_00AA, 0, 32'h0);
    xact("lb10",   1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF_FFBB, 0, 32'h0);
    xact("lws10",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'h8899_AABB, 0, 32'h0);
    xact("sb11",   1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00CC, 3, 1'b0, 32'h0, 1, 32'h8899_CCBB);
    xact("sh12",   1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234, 3, 1'b0, 32'h0, 1, 32'h1234_CCBB);
    xact("sw10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1, 32'hDEAD_BEEF);
    xact("lw10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0, 32'h0);
    xact("e_lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);
    xact("e_lh11", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);
    xact("e_sz3",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);
    xact("e_sh13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);
    @(negedge clk);
    chk("mem10", mem[4], 32'hDEAD_BEEF);

    // Reset while a byte store sits in RMW_RD
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w0 = we_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ready", {31'b0, req_ready}, 32'd1);
    chk("ar_rvalid", {31'b0, resp_valid}, 32'd0);
    chk("ar_rerr", {31'b0, resp_err}, 32'd0);
    chk("ar_rdata", resp_rdata, 32'h0);
    chk("ar_mwe", {31'b0, mem_we}, 32'd0);
    chk("ar_maddr", mem_addr, 32'h0);
    chk("ar_mwd", mem_wd, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("ar_noresp", {31'b0, seen}, 32'd0);
    chk("ar_wecnt", we_cnt - w0, 32'd0);
    chk("ar_mem14", mem[5], 32'h1122_3344);
    chk("ar_ready2", {31'b0, req_ready}, 32'd1);

    // Back-to-back lw/sb with req_valid held high
    t_we[0] = 1'b0; t_a[0] = 32'h18; t_wd[0] = 32'h0;  t_rd[0] = 32'h0102_0304; t_gap[0] = 3;
    t_we[1] = 1'b1; t_a[1] = 32'h19; t_wd[1] = 32'hEE; t_rd[1] = 32'h0;         t_gap[1] = 4;
    t_we[2] = 1'b0; t_a[2] = 32'h18; t_wd[2] = 32'h0;  t_rd[2] = 32'h0102_EE04; t_gap[2] = 3;
    t_we[3] = 1'b1; t_a[3] = 32'h1B; t_wd[3] = 32'h77; t_rd[3] = 32'h0;         t_gap[3] = 4;
    t_we[4] = 1'b0; t_a[4] = 32'h18; t_wd[4] = 32'h0;  t_rd[4] = 32'h7702_EE04; t_gap[4] = 3;
    @(negedge clk);
    chk("tp_ready0", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid  = 1'b1;
      req_we     = t_we[i];
      req_size   = t_we[i] ? 2'b00 : 2'b10;
      req_signed = 1'b0;
      req_addr   = t_a[i];
      req_wdata  = t_wd[i];
      @(posedge clk);
      #1;
      if (i < 4) set_garbage();
      else req_valid = 1'b0;
      n = 0; seen = 1'b0;
      while (n < 8) begin
        @(negedge clk);
        n++;
        if (resp_valid) begin
          seen = 1'b1;
          chk($sformatf("tp_rd%0d", i), resp_rdata, t_rd[i]);
        end
        if (req_ready) break;
      end
      chk($sformatf("tp_gap%0d", i), n, t_gap[i]);
      chk($sformatf("tp_resp%0d", i), {31'b0, seen}, 32'd1);
    end
    chk("tp_mem18", mem[6], 32'h7702_EE04);
    chk("tp_mem3c", mem[15], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
